pe_mac_seq_ctrl: RTL and testbench

- Parametrised second-generation controller for a single MAC processing element (PE).
- Sequences one output partial sum over a kernel_h x kernel_w x num_ch window: load ipsum, run N MACs, emit opsum.
- Adds rectangular kernels, multi-channel accumulation, operand-stall handshake, abort, kernel index outputs, config error flag.
- Drives the existing PE datapath muxes (mult/acc/opsum/ipsum selects, active-low) and the PE address generators.

---
 rtl/pe_ctrl_pkg.sv | 37 +++
 rtl/pe_kernel_idx_cnt.sv | 58 +++++
 rtl/pe_mac_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_pe_mac_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the MAC processing-element controller:
// FSM state encoding and the active-low datapath select vector per state.
package pe_ctrl_pkg;

  localparam int KS_W_DEF = 8;
  localparam int CH_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IPSUM = 2'd1,
    ST_OP    = 2'd2,
    ST_OPSUM = 2'd3
  } state_t;

  // Field order matches the port order: mult, acc, opsum, ipsum (all active-low).
  typedef struct packed {
    logic mult_seln;
    logic acc_seln;
    logic opsum_seln;
    logic ipsum_seln;
  } sel_t;

  localparam sel_t SEL_IDLE  = '{mult_seln: 1'b1, acc_seln: 1'b1, opsum_seln: 1'b1, ipsum_seln: 1'b1};
  localparam sel_t SEL_IPSUM = '{mult_seln: 1'b1, acc_seln: 1'b1, opsum_seln: 1'b1, ipsum_seln: 1'b0};
  localparam sel_t SEL_OP    = '{mult_seln: 1'b0, acc_seln: 1'b0, opsum_seln: 1'b1, ipsum_seln: 1'b1};
  localparam sel_t SEL_OPSUM = '{mult_seln: 1'b0, acc_seln: 1'b0, opsum_seln: 1'b0, ipsum_seln: 1'b1};

  function automatic sel_t sel_of(input state_t s);
    case (s)
      ST_IPSUM: sel_of = SEL_IPSUM;
      ST_OP:    sel_of = SEL_OP;
      ST_OPSUM: sel_of = SEL_OPSUM;
      default:  sel_of = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pe_kernel_idx_cnt.sv
// Nested col -> row -> channel counter walking one kernel window; last flags
// the final position so the FSM can leave OP on that accept.
module pe_kernel_idx_cnt
  import pe_ctrl_pkg::*;
#(
  parameter int KS_W = KS_W_DEF,
  parameter int CH_W = CH_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic [KS_W-1:0] lim_h,
  input  logic [KS_W-1:0] lim_w,
  input  logic [CH_W-1:0] lim_c,
  output logic [KS_W-1:0] row_idx,
  output logic [KS_W-1:0] col_idx,
  output logic [CH_W-1:0] ch_idx,
  output logic            last
);

  logic col_last;
  logic row_last;
  logic ch_last;

  // Compare against limit-1 at field width; limits are nonzero whenever en can be high.
  assign col_last = (col_idx == lim_w - KS_W'(1));
  assign row_last = (row_idx == lim_h - KS_W'(1));
  assign ch_last  = (ch_idx  == lim_c - CH_W'(1));
  assign last     = col_last & row_last & ch_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_idx <= '0;
      col_idx <= '0;
      ch_idx  <= '0;
    end else if (clr) begin
      row_idx <= '0;
      col_idx <= '0;
      ch_idx  <= '0;
    end else if (en) begin
      if (col_last) begin
        col_idx <= '0;
        if (row_last) begin
          row_idx <= '0;
          ch_idx  <= ch_last ? '0 : ch_idx + CH_W'(1);
        end else begin
          row_idx <= row_idx + KS_W'(1);
        end
      end else begin
        col_idx <= col_idx + KS_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_mac_seq_ctrl.sv
// Sequencer for one MAC PE output: load ipsum, run kh*kw*nc accepted MACs,
// emit opsum. Owns the FSM, the config latch and the select decode.
module pe_mac_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int KS_W = KS_W_DEF,
  parameter int CH_W = CH_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [KS_W-1:0] kernel_h,
  input  logic [KS_W-1:0] kernel_w,
  input  logic [CH_W-1:0] num_ch,
  input  logic            in_valid,
  output logic            mult_seln,
  output logic            acc_seln,
  output logic            opsum_seln,
  output logic            ipsum_seln,
  output logic            hold_psum,
  output logic [KS_W-1:0] row_idx,
  output logic [KS_W-1:0] col_idx,
  output logic [CH_W-1:0] ch_idx,
  output logic            busy,
  output logic            done,
  output logic            err_cfg
);

  state_t          state;
  logic [KS_W-1:0] kh_q;
  logic [KS_W-1:0] kw_q;
  logic [CH_W-1:0] nc_q;
  logic            cfg_ok;
  logic            idx_last;
  logic            accept;
  sel_t            sel;

  assign cfg_ok = (kernel_h != '0) && (kernel_w != '0) && (num_ch != '0);
  assign accept = (state == ST_OP) && in_valid;

  pe_kernel_idx_cnt #(
    .KS_W(KS_W),
    .CH_W(CH_W)
  ) u_idx_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (abort || (state == ST_IPSUM)),
    .en     (accept),
    .lim_h  (kh_q),
    .lim_w  (kw_q),
    .lim_c  (nc_q),
    .row_idx(row_idx),
    .col_idx(col_idx),
    .ch_idx (ch_idx),
    .last   (idx_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      kh_q    <= '0;
      kw_q    <= '0;
      nc_q    <= '0;
      err_cfg <= 1'b0;
    end else begin
      err_cfg <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                kh_q  <= kernel_h;
                kw_q  <= kernel_w;
                nc_q  <= num_ch;
                state <= ST_IPSUM;
              end else begin
                err_cfg <= 1'b1;
              end
            end
          end
          ST_IPSUM: state <= ST_OP;
          ST_OP: begin
            if (accept && idx_last) state <= ST_OPSUM;
          end
          ST_OPSUM: begin
            // Back-to-back windows skip IDLE so the PE sees no bubble.
            if (start && cfg_ok) begin
              kh_q  <= kernel_h;
              kw_q  <= kernel_w;
              nc_q  <= num_ch;
              state <= ST_IPSUM;
            end else begin
              err_cfg <= start;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel       = sel_of(state);
    hold_psum = 1'b0;
    if (accept && (row_idx == '0) && (col_idx == '0) && (ch_idx == '0)) hold_psum = 1'b1;
  end

  assign mult_seln  = sel.mult_seln;
  assign acc_seln   = sel.acc_seln;
  assign opsum_seln = sel.opsum_seln;
  assign ipsum_seln = sel.ipsum_seln;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_OPSUM);

endmodule

// File: tb/tb_pe_mac_seq_ctrl.sv
// Self-checking bench for pe_mac_seq_ctrl: a window-level model (accept count,
// config latch) predicts every output each cycle; directed runs pin latencies.
module tb_pe_mac_seq_ctrl;

  localparam int KS_W = 8;
  localparam int CH_W = 4;

  logic            clk;
  logic            rstn;
  logic            start;
  logic            abort;
  logic [KS_W-1:0] kernel_h;
  logic [KS_W-1:0] kernel_w;
  logic [CH_W-1:0] num_ch;
  logic            in_valid;
  logic            mult_seln, acc_seln, opsum_seln, ipsum_seln;
  logic            hold_psum;
  logic [KS_W-1:0] row_idx;
  logic [KS_W-1:0] col_idx;
  logic [CH_W-1:0] ch_idx;
  logic            busy, done, err_cfg;

  pe_mac_seq_ctrl #(.KS_W(KS_W), .CH_W(CH_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .kernel_h  (kernel_h),
    .kernel_w  (kernel_w),
    .num_ch    (num_ch),
    .in_valid  (in_valid),
    .mult_seln (mult_seln),
    .acc_seln  (acc_seln),
    .opsum_seln(opsum_seln),
    .ipsum_seln(ipsum_seln),
    .hold_psum (hold_psum),
    .row_idx   (row_idx),
    .col_idx   (col_idx),
    .ch_idx    (ch_idx),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Window-level model: phase 0 idle, 1 load ipsum, 2 MAC, 3 emit opsum.
  // Indices follow from the number of MACs accepted so far in the window.
  int     m_ph, m_kh, m_kw, m_nc;
  longint m_k;
  bit     m_err;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = 0; m_kh = 0; m_kw = 0; m_nc = 0; m_k = 0; m_err = 0;
    end else begin
      bit ok;
      ok    = (kernel_h != 0) && (kernel_w != 0) && (num_ch != 0);
      m_err = 0;
      if (abort) begin
        m_ph = 0;
        m_k  = 0;
      end else begin
        case (m_ph)
          0: if (start) begin
               if (ok) begin
                 m_kh = kernel_h; m_kw = kernel_w; m_nc = num_ch; m_ph = 1;
               end else m_err = 1;
             end
          1: begin m_ph = 2; m_k = 0; end
          2: if (in_valid) begin
               m_k++;
               if (m_k == longint'(m_kh) * m_kw * m_nc) begin m_k = 0; m_ph = 3; end
             end
          default: begin
            if (start && ok) begin
              m_kh = kernel_h; m_kw = kernel_w; m_nc = num_ch; m_ph = 1;
            end else begin
              m_err = start;
              m_ph  = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rstn && chk_en) begin
      logic [3:0] e_sel;
      int e_row, e_col, e_ch;
      case (m_ph)
        0:       e_sel = 4'b1111;
        1:       e_sel = 4'b1110;
        2:       e_sel = 4'b0011;
        default: e_sel = 4'b0001;
      endcase
      e_row = 0; e_col = 0; e_ch = 0;
      if (m_kw != 0) begin
        e_col = int'(m_k % m_kw);
        e_row = int'((m_k / m_kw) % m_kh);
        e_ch  = int'((m_k / (m_kw * m_kh)) % m_nc);
      end
      check("sel", {mult_seln, acc_seln, opsum_seln, ipsum_seln}, e_sel);
      check("hold_psum", hold_psum, (m_ph == 2) && in_valid && (m_k == 0));
      check("busy", busy, m_ph != 0);
      check("done", done, m_ph == 3);
      check("err_cfg", err_cfg, m_err);
      check("row_idx", row_idx, e_row);
      check("col_idx", col_idx, e_col);
      check("ch_idx", ch_idx, e_ch);
    end
  end

  // mode 0: in_valid always 1; 1: 1,0,1,0... from the first OP cycle; 2: random.
  task automatic run_window(input int kh, input int kw, input int nc, input int mode,
                            input int max_cyc, output int cyc, output int holds,
                            output int accepts, output int ch_at6);
    @(negedge clk);
    kernel_h = KS_W'(kh); kernel_w = KS_W'(kw); num_ch = CH_W'(nc);
    start = 1'b1; in_valid = 1'b0;
    cyc = 0; holds = 0; accepts = 0; ch_at6 = -1;
    forever begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      kernel_h = KS_W'($urandom);
      kernel_w = KS_W'($urandom);
      num_ch   = CH_W'($urandom);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (hold_psum) holds++;
      if (in_valid && !mult_seln && opsum_seln) begin
        accepts++;
        if (accepts == 7) ch_at6 = int'(ch_idx);
      end
      if (done) break;
      if (cyc >= max_cyc) begin
        n_checks++; n_errors++;
        $display("FAIL run_timeout: no done after %0d cycles, required by %0d", cyc, max_cyc);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int cyc, holds, acc, ch6, cnt_a, cnt_b;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    kernel_h = '0; kernel_w = '0; num_ch = '0;
    #12;
    check("rst_sel", {mult_seln, acc_seln, opsum_seln, ipsum_seln}, 4'b1111);
    check("rst_busy_done_err", {busy, done, err_cfg, hold_psum}, 4'b0000);
    check("rst_idx", {row_idx, col_idx, ch_idx}, 0);
    @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1;

    // 3x3x1, no stalls: IPSUM + 9 OP cycles, OPSUM 11 cycles after start.
    run_window(3, 3, 1, 0, 40, cyc, holds, acc, ch6);
    check("t1_latency", cyc, 11);
    check("t1_holds", holds, 1);
    check("t1_accepts", acc, 9);

    // 2x3x2 with alternating in_valid: 12 accepts over 23 OP cycles.
    run_window(2, 3, 2, 1, 80, cyc, holds, acc, ch6);
    check("t2_latency", cyc, 25);
    check("t2_accepts", acc, 12);
    check("t2_ch_at_accept6", ch6, 1);

    // 1x1x1 with start held: done every third cycle, never idle.
    @(negedge clk);
    kernel_h = 1; kernel_w = 1; num_ch = 1; start = 1'b1; in_valid = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      cnt_a += int'(done); cnt_b += int'(busy);
    end
    check("t3_done_pulses", cnt_a, 3);
    check("t3_busy_cycles", cnt_b, 9);
    start = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;

    // Zero kernel width: rejected, single err pulse, stays idle.
    @(negedge clk);
    kernel_h = 3; kernel_w = 0; num_ch = 1; start = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b0; #1;
      cnt_a += int'(err_cfg); cnt_b += int'(busy);
    end
    check("t4_err_pulses", cnt_a, 1);
    check("t4_busy_cycles", cnt_b, 0);

    // Abort on the 4th OP cycle of a 3x3x1 window, then a clean 2x2x1 window.
    @(negedge clk);
    kernel_h = 3; kernel_w = 3; num_ch = 1; start = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    check("t5_idle_after_abort", busy, 0);
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1; cnt_a += int'(done);
    end
    check("t5_no_done", cnt_a, 0);
    in_valid = 1'b0;
    run_window(2, 2, 1, 0, 30, cyc, holds, acc, ch6);
    check("t5_latency", cyc, 6);

    // Asynchronous reset between clock edges in the middle of OP.
    @(negedge clk);
    kernel_h = 3; kernel_w = 3; num_ch = 1; start = 1'b1; in_valid = 1'b1;
    repeat (4) begin @(negedge clk); start = 1'b0; end
    #3 rstn = 1'b0;
    #1;
    check("t6_rst_sel", {mult_seln, acc_seln, opsum_seln, ipsum_seln}, 4'b1111);
    check("t6_rst_busy_done", {busy, done, hold_psum, err_cfg}, 4'b0000);
    check("t6_rst_idx", {row_idx, col_idx, ch_idx}, 0);
    @(negedge clk);
    in_valid = 1'b0; rstn = 1'b1;

    // Wide limits at full field width.
    run_window(255, 4, 15, 0, 16000, cyc, holds, acc, ch6);
    check("t7_accepts", acc, 15300);
    check("t7_latency", cyc, 15302);
    run_window(2, 255, 15, 2, 20000, cyc, holds, acc, ch6);
    check("t8_accepts", acc, 7650);
    check("t8_holds", holds, 1);

    // Random small windows with random stalls.
    for (int r = 0; r < 8; r++) begin
      int kh, kw, nc;
      kh = $urandom_range(1, 5); kw = $urandom_range(1, 5); nc = $urandom_range(1, 3);
      run_window(kh, kw, nc, 2, 600, cyc, holds, acc, ch6);
      check("rnd_accepts", acc, kh * kw * nc);
      check("rnd_holds", holds, 1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
